traffic_phase_timer: RTL
========================

Name: traffic_phase_timer

Overview:
- Parametrised phase sequencer and timer for the traffic-light controller.
- Cycles through NUM_PHASES phases (e.g. green/yellow/red). Each phase lasts a runtime-programmable number of ticks.
- Ticks come from a built-in clock prescaler.
- Reports the current phase (one-hot and index), the elapsed tick count, and a one-cycle pulse at every phase change. Feeds the light-decode logic.

Parameters:
- NUM_PHASES, 3, number of phases in the cycle (>=2).
- CNT_W, 8, width of each phase duration and of the tick counter.
- TICK_DIV, 1, clock cycles per tick (>=1); prescaler width is $clog2(TICK_DIV), minimum 1.
- EXT_TICKS, 4, ticks added by an extension request (used only with the optional feature).
- Derived localparam IDX_W = max(1, $clog2(NUM_PHASES)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; 0 freezes prescaler, counter and phase.
- force_next  in  1  end the current phase at the next clock edge.
- dur  in  NUM_PHASES*CNT_W  per-phase duration in ticks; phase k uses dur[k*CNT_W +: CNT_W].
- ext_req  in  1  request to extend the current phase (present only with PHASE_TIMER_EXTEND_EN).
- phase_onehot  out  NUM_PHASES  current phase, one-hot.
- phase_idx  out  IDX_W  current phase index.
- count  out  CNT_W  ticks elapsed in the current phase.
- phase_done  out  1  one-cycle pulse on each phase change.

Behaviour:
- Reset (rst=0, asynchronous):
  - phase_idx=0, phase_onehot=1, count=0, phase_done=0.
  - Prescaler=0; extension-used flag cleared.
- All state is registered; outputs come straight from registers.
- Prescaler:
  - Increments on each clk with en=1.
  - At TICK_DIV-1 it produces an internal tick and wraps to 0.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- Effective duration D = dur[phase_idx], except dur=0 is treated as 1.
  - D is sampled every cycle, so a change takes effect immediately.
- On a tick:
  - If count >= D-1: count<=0, phase advances (NUM_PHASES-1 wraps to 0), phase_done<=1.
  - Otherwise count<=count+1.
- A phase therefore lasts exactly D ticks (D*TICK_DIV clk cycles) when en is held high.
- If dur shrinks below count+1 mid-phase, the phase ends at the next tick. There is no count overflow or wrap.
- force_next=1 on a clock edge:
  - Phase advances, count<=0, prescaler<=0, phase_done<=1.
  - Acts regardless of en and tick, and takes priority over a simultaneous terminal tick, so the phase advances by exactly one.
- phase_done:
  - High for exactly one clk, in the first cycle the new phase is visible on the outputs.
  - Otherwise 0; it is cleared on any cycle without a phase change, including en=0.
- en=0: all state holds except phase_done, which clears. force_next still acts.
- Reset mid-phase aborts immediately to phase 0, count 0. The first phase after release lasts the full D0.

Optional Feature:
- Macro PHASE_TIMER_EXTEND_EN.
- Defined:
  - The ext_req port exists.
  - ext_req=1 on any clock edge while the extension-used flag is 0 sets the flag.
  - Effective duration becomes min(D+EXT_TICKS, 2^CNT_W-1), computed at CNT_W+1 bits and saturated.
  - Further requests in the same phase are ignored. The flag clears on every phase change.
  - An ext_req in the same cycle as a terminal tick is ignored, and the phase ends normally.
- Not defined: no ext_req port; durations are exactly D.

Test Plan:
- Cycle timing. NUM_PHASES=3, TICK_DIV=4, dur={4,2,5} (phase0=5, phase1=2, phase2=4), en=1 after reset.
  - Required: phase 0 lasts 20 clk, phase 1 lasts 8, phase 2 lasts 16, then back to phase 0.
  - phase_done pulses once per change; count runs 0..4 in phase 0.
- Zero duration. dur[1]=0.
  - Required: phase 1 lasts 1 tick (4 clk); no hang and no count wrap.
- Freeze and force.
  - en=0 for 10 cycles mid phase 0 at count=2: outputs hold and phase_done=0. Resume: the phase completes after the remaining ticks.
  - force_next pulsed at count=1 with en=0: next cycle phase_idx=1, count=0, phase_done=1.
- Simultaneous events and live duration.
  - force_next coincides with phase 0 terminal tick: advances exactly one phase, to 1.
  - dur[0] lowered from 5 to 2 at count=3: phase ends on the next tick.
- Reset mid-operation. rst=0 asynchronously during phase 2, count=3.
  - Required: outputs immediately show phase 0, count 0, phase_done 0.
  - After release, phase 0 lasts the full 20 clk.
- Extension (PHASE_TIMER_EXTEND_EN, EXT_TICKS=4). ext_req pulsed twice in phase 0.
  - Required: phase 0 lasts 9 ticks (36 clk); the next phase 0 reverts to 5 ticks.
  - With dur[0]=253, CNT_W=8: extended length saturates at 255 ticks.

Source files
------------

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase sequencer for the traffic-light controller.
// Steps through NUM_PHASES phases, each lasting a runtime-programmable number
// of prescaled ticks. Reports the phase (one-hot and index), the ticks elapsed
// in the phase and a one-cycle pulse on every phase change.
// Optional feature: define PHASE_TIMER_EXTEND_EN to add the ext_req port, which
// lengthens the current phase once by EXT_TICKS ticks (saturating).
module traffic_phase_timer #(
  parameter int NUM_PHASES = 3,
  parameter int CNT_W      = 8,
  parameter int TICK_DIV   = 1,
  parameter int EXT_TICKS  = 4,
  localparam int IDX_W     = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        force_next,
  input  logic [NUM_PHASES*CNT_W-1:0] dur,
`ifdef PHASE_TIMER_EXTEND_EN
  input  logic                        ext_req,
`endif
  output logic [NUM_PHASES-1:0]       phase_onehot,
  output logic [IDX_W-1:0]            phase_idx,
  output logic [CNT_W-1:0]            count,
  output logic                        phase_done
);

  localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W:0]  SAT_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]  EXT_ADD = (CNT_W + 1)'(EXT_TICKS);

  logic [PS_W-1:0]  presc;
  logic             ext_active;
  logic [CNT_W-1:0] dur_sel;
  logic [CNT_W-1:0] d_base;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W:0]   d_sum;
  logic             tick;
  logic             terminal;
  logic [IDX_W-1:0] next_idx;

  // Live duration of the current phase: zero means one tick, extension saturates
  always_comb begin
    dur_sel = dur[phase_idx*CNT_W +: CNT_W];
    d_base  = (dur_sel == '0) ? CNT_W'(1) : dur_sel;
    d_sum   = {1'b0, d_base} + EXT_ADD;
    d_eff   = d_base;
    if (ext_active) begin
      d_eff = (d_sum > SAT_MAX) ? {CNT_W{1'b1}} : d_sum[CNT_W-1:0];
    end
  end

  // Tick strobe, end-of-phase detect (>= so a shrunk duration ends at once) and next index
  always_comb begin
    tick     = en && (presc == PS_LAST);
    terminal = (count >= (d_eff - CNT_W'(1)));
    next_idx = (phase_idx == IDX_W'(NUM_PHASES - 1)) ? '0 : phase_idx + IDX_W'(1);
  end

  // Prescaler, tick counter and phase register; force_next overrides the timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc        <= '0;
      count        <= '0;
      phase_idx    <= '0;
      phase_onehot <= NUM_PHASES'(1);
      phase_done   <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      if (force_next) begin
        presc        <= '0;
        count        <= '0;
        phase_idx    <= next_idx;
        phase_onehot <= NUM_PHASES'(1) << next_idx;
        phase_done   <= 1'b1;
      end else if (en) begin
        if (tick) begin
          presc <= '0;
          if (terminal) begin
            count        <= '0;
            phase_idx    <= next_idx;
            phase_onehot <= NUM_PHASES'(1) << next_idx;
            phase_done   <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end else begin
          presc <= presc + PS_W'(1);
        end
      end
    end
  end

`ifdef PHASE_TIMER_EXTEND_EN
  logic ext_used;

  // Extension flag: set by the first request in a phase, cleared on every phase change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_used <= 1'b0;
    end else if (force_next || (tick && terminal)) begin
      ext_used <= 1'b0;
    end else if (ext_req) begin
      ext_used <= 1'b1;
    end
  end

  assign ext_active = ext_used;
`else
  assign ext_active = 1'b0;
`endif

endmodule
